uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver, receive-side companion of UartTx.
//
// Recovers 8-bit frames (start, 8 data LSB-first, optional even/odd parity,
// one or two stop bits) by sampling the synchronized line in the middle of
// each bit. Every completed frame produces a one-cycle data_valid_o strobe
// together with updated data_o, parity_error_o and framing_error_o, which
// then hold until the next strobe.
//
// Ports:
//   clock_i          system clock
//   reset_n_i        asynchronous active-low reset
//   serial_i         asynchronous serial line, idle high
//   two_stop_bits_i  expect two stop bits (latched at start bit)
//   parity_bit_i     expect a parity bit (latched at start bit)
//   parity_even_i    1 = even parity, 0 = odd (latched at start bit)
//   clock_divider_i  clock cycles per bit; 0 behaves as 1
//   data_o           last received byte
//   data_valid_o     one-cycle strobe for data_o and the error flags
//   parity_error_o   parity mismatch in the last frame
//   framing_error_o  a stop bit sampled low in the last frame
//   busy_o           high whenever the receiver is not idle (incl. reset)
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN
//   When defined, each bit decision is the 2-of-3 majority of the line one
//   cycle before, at and after the nominal sample point (divider >= 3).
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_DIVIDER_WIDTH = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic                           serial_i,
    input  logic                           two_stop_bits_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    output logic [7:0]                     data_o,
    output logic                           data_valid_o,
    output logic                           parity_error_o,
    output logic                           framing_error_o,
    output logic                           busy_o
);

    localparam int W = CLOCK_DIVIDER_WIDTH;
    localparam logic [W-1:0] TIMER_ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        POST_RESET = 3'd0,
        IDLE       = 3'd1,
        START      = 3'd2,
        DATA       = 3'd3,
        PARITY     = 3'd4,
        STOP       = 3'd5,
        WAIT_HIGH  = 3'd6
    } state_t;

    state_t       state_q, state_d;
    logic         rxMeta_q, rxSync_q;
    logic [W-1:0] bitTimer_q, bitTimer_d;
    logic [W-1:0] dm1_q, dm1_d;
    logic [W-1:0] liveDm1, half, samplePoint;
    logic [3:0]   bitCount_q, bitCount_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   data_q, data_d;
    logic         twoStop_q, twoStop_d;
    logic         parEn_q, parEn_d;
    logic         parEven_q, parEven_d;
    logic         parityErr_q, parityErr_d;
    logic         frameErr_q, frameErr_d;
    logic         valid_q, valid_d;
    logic         parityFlag_q, parityFlag_d;
    logic         framingFlag_q, framingFlag_d;
    logic         rxSample;
    logic         frameNow;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= serial_i;
            rxSync_q <= rxMeta_q;
        end
    end

    // The divider in use during a frame is captured at the start bit; the
    // live value only matters while waiting for a frame.
    always_comb begin
        liveDm1 = (clock_divider_i == '0) ? '0 : clock_divider_i - TIMER_ONE;
        half    = dm1_q >> 1;
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [W-1:0] TIMER_TWO = {{(W-2){1'b0}}, 2'b10};
    logic [1:0] rxHist_q;

    // Two previous line values so the vote can span nominal-1 .. nominal+1.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rxHist_q <= 2'b11;
        end else begin
            rxHist_q <= {rxHist_q[0], rxSync_q};
        end
    end

    // Decision is taken one cycle after the nominal point; delaying the start
    // sample by one cycle shifts every later sample by the same amount.
    always_comb begin
        if (dm1_q >= TIMER_TWO) begin
            samplePoint = half + TIMER_ONE;
            rxSample    = (rxHist_q[1] & rxHist_q[0]) | (rxHist_q[1] & rxSync_q) |
                          (rxHist_q[0] & rxSync_q);
        end else begin
            samplePoint = half;
            rxSample    = rxSync_q;
        end
    end
`else
    always_comb begin
        samplePoint = half;
        rxSample    = rxSync_q;
    end
`endif

    // Next-state and datapath logic. The bit timer free-runs 0..Dm1 once a
    // start bit is confirmed so each data/parity/stop sample lands one full
    // bit-time after the previous one.
    always_comb begin
        state_d       = state_q;
        bitTimer_d    = bitTimer_q;
        bitCount_d    = bitCount_q;
        dm1_d         = dm1_q;
        shift_d       = shift_q;
        data_d        = data_q;
        twoStop_d     = twoStop_q;
        parEn_d       = parEn_q;
        parEven_d     = parEven_q;
        parityErr_d   = parityErr_q;
        frameErr_d    = frameErr_q;
        parityFlag_d  = parityFlag_q;
        framingFlag_d = framingFlag_q;
        valid_d       = 1'b0;
        frameNow      = frameErr_q | ~rxSample;

        case (state_q)
            // Need 12 uninterrupted high bit-times before trusting the line.
            POST_RESET: begin
                if (!rxSync_q) begin
                    bitTimer_d = '0;
                    bitCount_d = '0;
                end else if (bitTimer_q >= liveDm1) begin
                    bitTimer_d = '0;
                    if (bitCount_q == 4'd11) begin
                        bitCount_d = '0;
                        state_d    = IDLE;
                    end else begin
                        bitCount_d = bitCount_q + 4'd1;
                    end
                end else begin
                    bitTimer_d = bitTimer_q + TIMER_ONE;
                end
            end
            IDLE: begin
                if (!rxSync_q) begin
                    twoStop_d   = two_stop_bits_i;
                    parEn_d     = parity_bit_i;
                    parEven_d   = parity_even_i;
                    dm1_d       = liveDm1;
                    bitTimer_d  = '0;
                    bitCount_d  = '0;
                    parityErr_d = 1'b0;
                    frameErr_d  = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bitTimer_q == samplePoint) begin
                    if (rxSample) begin
                        state_d = IDLE;
                    end else begin
                        bitTimer_d = '0;
                        bitCount_d = '0;
                        state_d    = DATA;
                    end
                end else begin
                    bitTimer_d = bitTimer_q + TIMER_ONE;
                end
            end
            DATA: begin
                if (bitTimer_q == dm1_q) begin
                    bitTimer_d = '0;
                    shift_d    = {rxSample, shift_q[7:1]};
                    if (bitCount_q == 4'd7) begin
                        bitCount_d = '0;
                        state_d    = parEn_q ? PARITY : STOP;
                    end else begin
                        bitCount_d = bitCount_q + 4'd1;
                    end
                end else begin
                    bitTimer_d = bitTimer_q + TIMER_ONE;
                end
            end
            PARITY: begin
                if (bitTimer_q == dm1_q) begin
                    bitTimer_d  = '0;
                    parityErr_d = rxSample ^ (parEven_q ? ^shift_q : ~^shift_q);
                    state_d     = STOP;
                end else begin
                    bitTimer_d = bitTimer_q + TIMER_ONE;
                end
            end
            // A low final stop sample with the line still low means a break;
            // park in WAIT_HIGH so the break is not mistaken for a new start.
            STOP: begin
                if (bitTimer_q == dm1_q) begin
                    bitTimer_d = '0;
                    if (twoStop_q && (bitCount_q == 4'd0)) begin
                        bitCount_d = 4'd1;
                        frameErr_d = frameNow;
                    end else begin
                        bitCount_d    = '0;
                        data_d        = shift_q;
                        parityFlag_d  = parEn_q & parityErr_q;
                        framingFlag_d = frameNow;
                        valid_d       = 1'b1;
                        state_d       = (frameNow && !rxSync_q) ? WAIT_HIGH : IDLE;
                    end
                end else begin
                    bitTimer_d = bitTimer_q + TIMER_ONE;
                end
            end
            WAIT_HIGH: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= POST_RESET;
            bitTimer_q    <= '0;
            bitCount_q    <= '0;
            dm1_q         <= '0;
            shift_q       <= 8'h00;
            data_q        <= 8'h00;
            twoStop_q     <= 1'b0;
            parEn_q       <= 1'b0;
            parEven_q     <= 1'b0;
            parityErr_q   <= 1'b0;
            frameErr_q    <= 1'b0;
            valid_q       <= 1'b0;
            parityFlag_q  <= 1'b0;
            framingFlag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitTimer_q    <= bitTimer_d;
            bitCount_q    <= bitCount_d;
            dm1_q         <= dm1_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            twoStop_q     <= twoStop_d;
            parEn_q       <= parEn_d;
            parEven_q     <= parEven_d;
            parityErr_q   <= parityErr_d;
            frameErr_q    <= frameErr_d;
            valid_q       <= valid_d;
            parityFlag_q  <= parityFlag_d;
            framingFlag_q <= framingFlag_d;
        end
    end

    assign data_o          = data_q;
    assign data_valid_o    = valid_q;
    assign parity_error_o  = parityFlag_q;
    assign framing_error_o = framingFlag_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;

    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        serial_i = 1'b1;
    logic        two_stop_bits_i = 1'b0;
    logic        parity_bit_i = 1'b0;
    logic        parity_even_i = 1'b0;
    logic [15:0] clock_divider_i = 16'd4;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        parity_error_o;
    logic        framing_error_o;
    logic        busy_o;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit VOTE_EN = 1'b1;
`else
    localparam bit VOTE_EN = 1'b0;
`endif

    // Expected flag state after the most recent strobe.
    logic [7:0] expData = 8'h00;
    logic       expPerr = 1'b0;
    logic       expFerr = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cycle;
    } strobe_t;

    strobe_t strobes[$];

    uart_rx #(.CLOCK_DIVIDER_WIDTH(16)) dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .serial_i        (serial_i),
        .two_stop_bits_i (two_stop_bits_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .clock_divider_i (clock_divider_i),
        .data_o          (data_o),
        .data_valid_o    (data_valid_o),
        .parity_error_o  (parity_error_o),
        .framing_error_o (framing_error_o),
        .busy_o          (busy_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cycleCount <= cycleCount + 1;

    // Record every strobe with the cycle it was seen in.
    always @(negedge clock_i) begin : monitor
        strobe_t s;
        if (data_valid_o === 1'b1) begin
            s.data  = data_o;
            s.perr  = parity_error_o;
            s.ferr  = framing_error_o;
            s.cycle = cycleCount;
            strobes.push_back(s);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: frame-level expectations from the frame format rules.
    function automatic void modelFrame(input logic [7:0] b, input bit pe, input bit even,
                                       input bit pbit, input int ns, input bit s1,
                                       input bit s2, input int d,
                                       output logic [7:0] eData, output bit ePerr,
                                       output bit eFerr, output int eLat);
        int  nBits;
        bit  wantParity;
        int  ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        wantParity = even ? (ones % 2 == 1) : (ones % 2 == 0);
        eData = b;
        ePerr = pe && (pbit != wantParity);
        eFerr = (s1 == 1'b0) || (ns == 2 && s2 == 1'b0);
        nBits = 1 + 8 + (pe ? 1 : 0) + ns;
        eLat  = 4 + (d - 1) / 2 + (nBits - 1) * d + ((VOTE_EN && d >= 3) ? 1 : 0);
    endfunction

    task automatic driveBit(input logic b, input int cycles);
        serial_i = b;
        repeat (cycles) @(posedge clock_i);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input int d, input bit pe, input bit even,
                             input bit pbit, input int ns, input bit s1, input bit s2,
                             output int startCycle);
        clock_divider_i = 16'(d);
        parity_bit_i    = pe;
        parity_even_i   = even;
        two_stop_bits_i = (ns == 2);
        startCycle      = cycleCount;
        driveBit(1'b0, d);
        // Mid-frame configuration changes must be ignored.
        parity_bit_i    = 1'($urandom);
        parity_even_i   = 1'($urandom);
        two_stop_bits_i = 1'($urandom);
        for (int i = 0; i < 8; i++) driveBit(b[i], d);
        if (pe) driveBit(pbit, d);
        driveBit(s1, d);
        if (ns == 2) driveBit(s2, d);
        serial_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        serial_i  = 1'b1;
        clock_divider_i = 16'd4;
        repeat (3) @(posedge clock_i);
        #1;
        testsRun++;
        if (busy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 1", busy_o); end
        testsRun++;
        if ({data_o, data_valid_o, parity_error_o, framing_error_o} !== 11'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got data=%h v=%b p=%b f=%b expected all 0",
                     data_o, data_valid_o, parity_error_o, framing_error_o);
        end
        reset_n_i = 1'b1;
        repeat (40) @(posedge clock_i);
        #1;
        testsRun++;
        if (busy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_holdoff: got %b expected 1", busy_o); end
        repeat (12) @(posedge clock_i);
        #1;
        testsRun++;
        if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_idle: got %b expected 0", busy_o); end
    endtask

    task automatic test_basic();
        logic [7:0] eD; bit eP, eF; int eL, sc, lat;
        strobes.delete();
        sendFrame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, sc);
        driveBit(1'b1, 8);
        modelFrame(8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 4, eD, eP, eF, eL);
        testsRun++;
        if (strobes.size() !== 1) begin testsFailed++; $display("[TB] FAIL basic_count: got %0d expected 1", strobes.size()); end
        if (strobes.size() >= 1) begin
            testsRun++;
            if ({strobes[0].data, strobes[0].perr, strobes[0].ferr} !== {eD, eP, eF}) begin
                testsFailed++;
                $display("[TB] FAIL basic_frame: got %h/%b/%b expected %h/%b/%b",
                         strobes[0].data, strobes[0].perr, strobes[0].ferr, eD, eP, eF);
            end
            lat = strobes[0].cycle - sc;
            testsRun++;
            if (lat < eL - 1 || lat > eL + 1) begin testsFailed++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, eL); end
        end
        testsRun++;
        if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_parity();
        logic [7:0] eD; bit eP, eF; int eL, sc;
        for (int k = 0; k < 2; k++) begin
            strobes.delete();
            sendFrame(8'h03, 8, 1'b1, 1'b1, (k == 0), 1, 1'b1, 1'b1, sc);
            driveBit(1'b1, 16);
            modelFrame(8'h03, 1'b1, 1'b1, (k == 0), 1, 1'b1, 1'b1, 8, eD, eP, eF, eL);
            testsRun++;
            if (strobes.size() !== 1) begin
                testsFailed++; $display("[TB] FAIL parity_count%0d: got %0d expected 1", k, strobes.size());
            end else if ({strobes[0].data, strobes[0].perr, strobes[0].ferr} !== {eD, eP, eF}) begin
                testsFailed++;
                $display("[TB] FAIL parity_frame%0d: got %h/%b/%b expected %h/%b/%b", k,
                         strobes[0].data, strobes[0].perr, strobes[0].ferr, eD, eP, eF);
            end
        end
    endtask

    task automatic test_break();
        int sc, lat, eL;
        clock_divider_i = 16'd4;
        parity_bit_i    = 1'b0;
        two_stop_bits_i = 1'b0;
        strobes.delete();
        sc = cycleCount;
        for (int i = 0; i < 9; i++) driveBit(1'b0, 4);
        driveBit(1'b0, 80);
        eL = 4 + 1 + 9 * 4 + (VOTE_EN ? 1 : 0);
        expData = 8'h00; expPerr = 1'b0; expFerr = 1'b1;
        testsRun++;
        if (strobes.size() !== 1) begin
            testsFailed++; $display("[TB] FAIL break_count: got %0d expected 1", strobes.size());
        end else begin
            if ({strobes[0].data, strobes[0].perr, strobes[0].ferr} !== {expData, expPerr, expFerr}) begin
                testsFailed++;
                $display("[TB] FAIL break_frame: got %h/%b/%b expected %h/%b/%b",
                         strobes[0].data, strobes[0].perr, strobes[0].ferr, expData, expPerr, expFerr);
            end
            lat = strobes[0].cycle - sc;
            testsRun++;
            if (lat < eL - 1 || lat > eL + 1) begin testsFailed++; $display("[TB] FAIL break_latency: got %0d expected %0d", lat, eL); end
        end
        testsRun++;
        if (busy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL break_busy_low: got %b expected 1", busy_o); end
        driveBit(1'b1, 4);
        testsRun++;
        if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL break_busy_high: got %b expected 0", busy_o); end
        driveBit(1'b1, 8);
    endtask

    task automatic test_glitch();
        clock_divider_i = 16'd16;
        strobes.delete();
        driveBit(1'b0, 1);
        serial_i = 1'b1;
        repeat (2) @(posedge clock_i);
        #1;
        testsRun++;
        if (busy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL glitch_start: got %b expected 1", busy_o); end
        repeat (11) @(posedge clock_i);
        #1;
        testsRun++;
        if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy_o); end
        testsRun++;
        if (strobes.size() !== 0 || {data_o, parity_error_o, framing_error_o} !== {expData, expPerr, expFerr}) begin
            testsFailed++;
            $display("[TB] FAIL glitch_flags: got n=%0d %h/%b/%b expected n=0 %h/%b/%b", strobes.size(),
                     data_o, parity_error_o, framing_error_o, expData, expPerr, expFerr);
        end
`ifdef UART_RX_MAJORITY_VOTE_EN
        // A one-cycle high spike in the middle of data bit 3 is outvoted.
        clock_divider_i = 16'd8;
        strobes.delete();
        for (int i = 0; i < 4; i++) driveBit(1'b0, 8);
        driveBit(1'b0, 4);
        driveBit(1'b1, 1);
        driveBit(1'b0, 3);
        for (int i = 0; i < 4; i++) driveBit(1'b0, 8);
        driveBit(1'b1, 24);
        testsRun++;
        if (strobes.size() !== 1 || strobes[0].data !== 8'h00 || strobes[0].ferr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL vote_glitch: got n=%0d data=%h expected n=1 data=00",
                     strobes.size(), (strobes.size() > 0) ? strobes[0].data : 8'hxx);
        end
`endif
    endtask

    task automatic test_two_stop();
        logic [7:0] eD; bit eP, eF; int eL, sc;
        strobes.delete();
        sendFrame(8'h5A, 4, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, sc);
        driveBit(1'b1, 12);
        modelFrame(8'h5A, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 4, eD, eP, eF, eL);
        testsRun++;
        if (strobes.size() !== 1) begin
            testsFailed++; $display("[TB] FAIL two_stop_count: got %0d expected 1", strobes.size());
        end else if ({strobes[0].data, strobes[0].perr, strobes[0].ferr} !== {eD, eP, eF}) begin
            testsFailed++;
            $display("[TB] FAIL two_stop_frame: got %h/%b/%b expected %h/%b/%b",
                     strobes[0].data, strobes[0].perr, strobes[0].ferr, eD, eP, eF);
        end
        testsRun++;
        if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL two_stop_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eD; bit eP, eF; int eL, sc1, sc2, lat;
        strobes.delete();
        sendFrame(8'h11, 4, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, sc1);
        sendFrame(8'h22, 4, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, sc2);
        driveBit(1'b1, 12);
        testsRun++;
        if (strobes.size() !== 2) begin
            testsFailed++; $display("[TB] FAIL b2b_count: got %0d expected 2", strobes.size());
        end else begin
            testsRun++;
            if (strobes[0].data !== 8'h11 || strobes[1].data !== 8'h22 ||
                strobes[0].ferr !== 1'b0 || strobes[1].ferr !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL b2b_order: got %h,%h expected 11,22", strobes[0].data, strobes[1].data);
            end
            modelFrame(8'h22, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 4, eD, eP, eF, eL);
            lat = strobes[1].cycle - sc2;
            testsRun++;
            if (lat < eL - 1 || lat > eL + 1) begin testsFailed++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, eL); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] eD; bit eP, eF; int eL, sc;
        strobes.delete();
        fork
            sendFrame(8'hC3, 4, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, sc);
            begin
                repeat (22) @(posedge clock_i);
                #1;
                reset_n_i = 1'b0;
                repeat (2) @(posedge clock_i);
                #1;
                testsRun++;
                if ({data_o, busy_o, data_valid_o} !== {8'h00, 1'b1, 1'b0}) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_values: got data=%h busy=%b v=%b expected 00/1/0",
                             data_o, busy_o, data_valid_o);
                end
                reset_n_i = 1'b1;
            end
        join
        driveBit(1'b1, 7 * 4);
        testsRun++;
        if (busy_o !== 1'b1 || strobes.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_holdoff: got busy=%b n=%0d expected busy=1 n=0", busy_o, strobes.size());
        end
        driveBit(1'b1, 3 * 4);
        testsRun++;
        if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_idle: got %b expected 0", busy_o); end
        sendFrame(8'h7E, 4, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, sc);
        driveBit(1'b1, 8);
        modelFrame(8'h7E, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 4, eD, eP, eF, eL);
        testsRun++;
        if (strobes.size() !== 1) begin
            testsFailed++; $display("[TB] FAIL midreset_count: got %0d expected 1", strobes.size());
        end else if ({strobes[0].data, strobes[0].perr, strobes[0].ferr} !== {eD, eP, eF}) begin
            testsFailed++;
            $display("[TB] FAIL midreset_frame: got %h/%b/%b expected %h/%b/%b",
                     strobes[0].data, strobes[0].perr, strobes[0].ferr, eD, eP, eF);
        end
    endtask

    task automatic test_random();
        logic [7:0] b, eD; bit pe, ev, pbit, s1, s2, eP, eF; int d, ns, sc, eL, lat;
        for (int i = 0; i < 10; i++) begin
            d    = $urandom_range(4, 12);
            pe   = 1'($urandom_range(0, 1));
            ev   = 1'($urandom_range(0, 1));
            ns   = $urandom_range(1, 2);
            b    = 8'($urandom);
            pbit = (ev ? ^b : ~^b) ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 4) != 0);
            s2   = ($urandom_range(0, 4) != 0);
            strobes.delete();
            sendFrame(b, d, pe, ev, pbit, ns, s1, s2, sc);
            driveBit(1'b1, 3 * d);
            modelFrame(b, pe, ev, pbit, ns, s1, s2, d, eD, eP, eF, eL);
            testsRun++;
            if (strobes.size() !== 1) begin
                testsFailed++; $display("[TB] FAIL random%0d_count: got %0d expected 1", i, strobes.size());
            end else begin
                testsRun++;
                if ({strobes[0].data, strobes[0].perr, strobes[0].ferr} !== {eD, eP, eF}) begin
                    testsFailed++;
                    $display("[TB] FAIL random%0d_frame: got %h/%b/%b expected %h/%b/%b (d=%0d pe=%b ev=%b ns=%0d)",
                             i, strobes[0].data, strobes[0].perr, strobes[0].ferr, eD, eP, eF, d, pe, ev, ns);
                end
                lat = strobes[0].cycle - sc;
                testsRun++;
                if (lat < eL - 1 || lat > eL + 1) begin
                    testsFailed++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, eL);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
